// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter behind a ZX-Uno register.
// A CPU write to PS2TXREG sends one byte to the device. A CPU read of the same
// register returns {busy, ack_error, timeout, 5'b0}.
// Optional build macro: PS2_TX_GLITCH_FILTER_EN. It adds an 8-sample
// level filter on the synced PS/2 clock line.
module ps2_host_tx #(
  parameter int         CLKFREQ  = 28000000,
  parameter logic [7:0] PS2TXREG = 8'h07
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] zxuno_addr,
  input  logic       zxuno_regrd,
  input  logic       zxuno_regwr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       oe_n,
  input  logic       ps2clk_in,
  input  logic       ps2data_in,
  output logic       ps2clk_oe,
  output logic       ps2data_oe,
  output logic       busy,
  output logic       tx_done
);

  // Phase lengths in clk cycles. Each is clamped to at least one cycle.
  localparam int N_INH = (CLKFREQ / 10000   < 1) ? 1 : CLKFREQ / 10000;
  localparam int N_ST  = (CLKFREQ / 1000000 < 1) ? 1 : CLKFREQ / 1000000;
  localparam int N_TO  = (CLKFREQ / 50      < 1) ? 1 : CLKFREQ / 50;
  localparam int TW    = $clog2(N_TO + 1);
  localparam logic [TW-1:0] INH_LAST = TW'(N_INH - 1);
  localparam logic [TW-1:0] ST_LAST  = TW'(N_ST - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(N_TO - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_INHIBIT  = 3'd1,
    S_START    = 3'd2,
    S_BITS     = 3'd3,
    S_ACK      = 3'd4,
    S_WAITIDLE = 3'd5
  } state_t;

  // Odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  state_t        state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    data_q, data_d;
  logic          clk_oe_q, clk_oe_d;
  logic          data_oe_q, data_oe_d;
  logic          busy_q, busy_d;
  logic          tx_done_q, tx_done_d;
  logic          ack_err_q, ack_err_d;
  logic          timeout_q, timeout_d;

  logic clk_meta_q, clk_sync_q, data_meta_q, data_sync_q;
  logic clk_prev_q;
  logic clk_lvl_s, fall_s, wr_hit_s, rd_hit_s;

  // Two-flop synchronizers for both pad inputs. They reset to the idle-high level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      clk_meta_q  <= ps2clk_in;
      clk_sync_q  <= clk_meta_q;
      data_meta_q <= ps2data_in;
      data_sync_q <= data_meta_q;
    end
  end

`ifdef PS2_TX_GLITCH_FILTER_EN
  logic [7:0] filt_sh_q, filt_sh_d;
  logic       filt_q, filt_d;

  // The filter level changes only after eight equal consecutive samples.
  always_comb begin
    filt_sh_d = {filt_sh_q[6:0], clk_sync_q};
    if (filt_sh_q == 8'hFF) begin
      filt_d = 1'b1;
    end else if (filt_sh_q == 8'h00) begin
      filt_d = 1'b0;
    end else begin
      filt_d = filt_q;
    end
  end

  // Filter shift register and output level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_sh_q <= 8'hFF;
      filt_q    <= 1'b1;
    end else begin
      filt_sh_q <= filt_sh_d;
      filt_q    <= filt_d;
    end
  end

  assign clk_lvl_s = filt_q;
`else
  assign clk_lvl_s = clk_sync_q;
`endif

  // Previous clock-line level. It is used to detect falling edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_prev_q <= 1'b1;
    end else begin
      clk_prev_q <= clk_lvl_s;
    end
  end

  assign fall_s   = clk_prev_q & ~clk_lvl_s;
  assign wr_hit_s = (zxuno_addr == PS2TXREG) && zxuno_regwr;
  assign rd_hit_s = (zxuno_addr == PS2TXREG) && zxuno_regrd;

  // Transfer FSM: next state, counters, registered line drives and status flags.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    data_d    = data_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    busy_d    = busy_q;
    tx_done_d = 1'b0;
    ack_err_d = ack_err_q;
    timeout_d = timeout_q;
    case (state_q)
      S_IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        busy_d    = 1'b0;
        if (wr_hit_s) begin
          data_d    = din;
          ack_err_d = 1'b0;
          timeout_d = 1'b0;
          cnt_d     = '0;
          clk_oe_d  = 1'b1;
          busy_d    = 1'b1;
          state_d   = S_INHIBIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          cnt_d     = '0;
          data_oe_d = 1'b1;
          state_d   = S_START;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      S_START: begin
        if (cnt_q == ST_LAST) begin
          cnt_d     = '0;
          bit_cnt_d = 4'd0;
          clk_oe_d  = 1'b0;
          state_d   = S_BITS;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      S_BITS, S_ACK, S_WAITIDLE: begin
        if (cnt_q == TO_LAST) begin
          // The device stopped responding. Give up and report a timeout.
          cnt_d     = '0;
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          busy_d    = 1'b0;
          tx_done_d = 1'b1;
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + TW'(1);
          if (state_q == S_BITS) begin
            if (fall_s) begin
              bit_cnt_d = bit_cnt_q + 4'd1;
              if (bit_cnt_q < 4'd8) begin
                data_oe_d = ~data_q[bit_cnt_q[2:0]];
              end else if (bit_cnt_q == 4'd8) begin
                data_oe_d = ~odd_parity(data_q);
              end else begin
                data_oe_d = 1'b0;
                state_d   = S_ACK;
              end
            end else begin
              bit_cnt_d = bit_cnt_q;
            end
          end else if (state_q == S_ACK) begin
            data_oe_d = 1'b0;
            if (fall_s) begin
              ack_err_d = data_sync_q;
              state_d   = S_WAITIDLE;
            end else begin
              state_d = S_ACK;
            end
          end else begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            if (clk_lvl_s && data_sync_q) begin
              cnt_d     = '0;
              busy_d    = 1'b0;
              tx_done_d = 1'b1;
              state_d   = S_IDLE;
            end else begin
              state_d = S_WAITIDLE;
            end
          end
        end
      end
      default: begin
        state_d   = S_IDLE;
        cnt_d     = '0;
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        busy_d    = 1'b0;
      end
    endcase
  end

  // State and datapath registers. A reset aborts any transfer silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= 4'd0;
      data_q    <= 8'h00;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      tx_done_q <= 1'b0;
      ack_err_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      data_q    <= data_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      busy_q    <= busy_d;
      tx_done_q <= tx_done_d;
      ack_err_q <= ack_err_d;
      timeout_q <= timeout_d;
    end
  end

  // Status readback. The bus is driven only while the CPU reads this register.
  always_comb begin
    if (rd_hit_s) begin
      oe_n = 1'b0;
      dout = {busy_q, ack_err_q, timeout_q, 5'b00000};
    end else begin
      oe_n = 1'b1;
      dout = 8'hFF;
    end
  end

  assign ps2clk_oe  = clk_oe_q;
  assign ps2data_oe = data_oe_q;
  assign busy       = busy_q;
  assign tx_done    = tx_done_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Testbench for ps2_host_tx. A behavioural PS/2 device model generates the clock,
// captures the frame on the wire and optionally acks. The expected frames and
// status bytes come from the framing rules computed directly from the data byte.
module tb_ps2_host_tx;

  localparam int         CLKFREQ  = 1000000;
  localparam logic [7:0] PS2TXREG = 8'h07;
  localparam int N_INH = CLKFREQ / 10000;
  localparam int N_ST  = (CLKFREQ / 1000000 < 1) ? 1 : CLKFREQ / 1000000;
  localparam int N_TO  = CLKFREQ / 50;
  localparam int HALF  = 40; // device half period in clk cycles (12.5 kHz, scaled)

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] zxuno_addr = 8'h00;
  logic       zxuno_regrd = 1'b0;
  logic       zxuno_regwr = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic       oe_n;
  logic       ps2clk_in, ps2data_in;
  logic       ps2clk_oe, ps2data_oe;
  logic       busy, tx_done;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;

  // Open-drain wires: a line is low if either side pulls it low.
  assign ps2clk_in  = dev_clk & ~ps2clk_oe;
  assign ps2data_in = dev_data & ~ps2data_oe;

  ps2_host_tx #(.CLKFREQ(CLKFREQ), .PS2TXREG(PS2TXREG)) dut (
    .clk(clk), .rst_n(rst_n), .zxuno_addr(zxuno_addr), .zxuno_regrd(zxuno_regrd),
    .zxuno_regwr(zxuno_regwr), .din(din), .dout(dout), .oe_n(oe_n),
    .ps2clk_in(ps2clk_in), .ps2data_in(ps2data_in), .ps2clk_oe(ps2clk_oe),
    .ps2data_oe(ps2data_oe), .busy(busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  // Count every tx_done pulse.
  always @(posedge clk) begin
    if (tx_done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic reg_write(input logic [7:0] d);
    @(negedge clk);
    zxuno_addr  = PS2TXREG;
    din         = d;
    zxuno_regwr = 1'b1;
    @(negedge clk);
    zxuno_regwr = 1'b0;
  endtask

  task automatic read_reg(input logic [7:0] a, output logic [7:0] v, output logic oe);
    @(negedge clk);
    zxuno_addr  = a;
    zxuno_regrd = 1'b1;
    #1;
    v  = dout;
    oe = oe_n;
    zxuno_regrd = 1'b0;
  endtask

  // Reference frame: 8 data bits LSB first, odd parity, then stop = 1.
  function automatic logic [9:0] frame(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, d};
  endfunction

  task automatic wait_not_busy(input int limit);
    int n = 0;
    while (busy && n < limit) begin
      cycles(1);
      n++;
    end
    if (busy) check_eq("busy_wait_expired", {31'd0, busy}, 32'd0);
  endtask

  // Device model: measures the inhibit time and clocks the frame in.
  // It stops early at falling edge abort_after, if that is nonzero.
  task automatic device_xfer(input logic ack, input int abort_after, input bit do_mid,
                             input logic [7:0] mid_d, input bit glitch,
                             output logic [9:0] bits, output int inh_len, output bit start_ok);
    logic held;
    inh_len = 0;
    bits    = '0;
    while (ps2clk_oe && inh_len < 10 * N_INH) begin
      cycles(1);
      inh_len++;
    end
    start_ok = ps2data_oe;
    for (int e = 1; e <= 10; e++) begin
      cycles(HALF);
      dev_clk = 1'b0;
      if (e == abort_after) begin
        cycles(6);
        return;
      end
      cycles(HALF);
      bits[e-1] = ps2data_in;
      dev_clk = 1'b1;
      if (do_mid && e == 3) reg_write(mid_d);
      if (glitch && e == 5) begin
        held = ps2data_oe;
        cycles(HALF / 2);
        dev_clk = 1'b0;
        cycles(3);
        dev_clk = 1'b1;
        cycles(12);
        check_eq("glitch_no_advance", {31'd0, ps2data_oe}, {31'd0, held});
      end
    end
    cycles(HALF);
    dev_data = ack ? 1'b0 : 1'b1;
    cycles(HALF);
    dev_clk = 1'b0;
    cycles(HALF);
    dev_clk  = 1'b1;
    dev_data = 1'b1;
  endtask

  task automatic run_xfer(input logic [7:0] d, input logic ack, input bit do_mid,
                          input logic [7:0] mid_d, input bit glitch);
    logic [9:0] bits;
    logic [7:0] st;
    logic       oe;
    int         inh_len, done0;
    bit         start_ok;
    done0 = done_cnt;
    reg_write(d);
    check_eq("busy_on_write", {31'd0, busy}, 32'd1);
    check_eq("clk_oe_on_write", {31'd0, ps2clk_oe}, 32'd1);
    device_xfer(ack, 0, do_mid, mid_d, glitch, bits, inh_len, start_ok);
    check_eq("inhibit_len_ok", {31'd0, (inh_len >= N_INH && inh_len <= N_INH + N_ST + 2)}, 32'd1);
    check_eq("start_bit", {31'd0, start_ok}, 32'd1);
    check_eq("frame_bits", {22'd0, bits}, {22'd0, frame(d)});
    wait_not_busy(20 * HALF);
    cycles(2);
    check_eq("done_pulses", done_cnt - done0, 32'd1);
    read_reg(PS2TXREG, st, oe);
    check_eq("status_oe_n", {31'd0, oe}, 32'd0);
    check_eq("status", {24'd0, st}, {24'd0, 1'b0, ~ack, 6'b000000});
    check_eq("lines_released", {30'd0, ps2clk_oe, ps2data_oe}, 32'd0);
  endtask

  initial begin
    logic [7:0] st;
    logic       oe;
    logic [9:0] bits;
    int         inh_len, done0, n;
    bit         start_ok, glitch_en;
`ifdef PS2_TX_GLITCH_FILTER_EN
    glitch_en = 1'b1;
`else
    glitch_en = 1'b0;
`endif
    cycles(3);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_oe", {30'd0, ps2clk_oe, ps2data_oe}, 32'd0);
    check_eq("rst_done", {31'd0, tx_done}, 32'd0);
    rst_n = 1'b1;
    cycles(3);
    read_reg(PS2TXREG, st, oe);
    check_eq("rst_status", {23'd0, oe, st}, {23'd0, 1'b0, 8'h00});
    read_reg(8'h08, st, oe);
    check_eq("other_addr_read", {23'd0, oe, st}, {23'd0, 1'b1, 8'hFF});

    // Byte ED with ack, then byte 00 without ack.
    run_xfer(8'hED, 1'b1, 1'b0, 8'h00, glitch_en);
    run_xfer(8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    // A write while busy must not disturb the frame or the flags.
    run_xfer(8'h55, 1'b1, 1'b1, 8'hAA, 1'b0);
    // Random bytes and random ack responses.
    for (int i = 0; i < 4; i++) begin
      run_xfer(8'($urandom), 1'($urandom_range(1, 0)), 1'b0, 8'h00, 1'b0);
    end

    // Device never clocks: expect a timeout after the 20 ms window.
    done0 = done_cnt;
    reg_write(8'hFF);
    n = 0;
    while (ps2clk_oe && n < 10 * N_INH) begin
      cycles(1);
      n++;
    end
    n = 0;
    while (busy && n < 3 * N_TO) begin
      cycles(1);
      n++;
    end
    check_eq("timeout_window_ok", {31'd0, (n >= N_TO - 2 && n <= N_TO + 2)}, 32'd1);
    cycles(2);
    check_eq("timeout_done", done_cnt - done0, 32'd1);
    read_reg(PS2TXREG, st, oe);
    check_eq("timeout_status", {24'd0, st}, 32'h20);
    check_eq("timeout_lines", {30'd0, ps2clk_oe, ps2data_oe}, 32'd0);

    // Reset after the 4th falling edge aborts the transfer without tx_done.
    done0 = done_cnt;
    reg_write(8'h3C);
    device_xfer(1'b1, 4, 1'b0, 8'h00, 1'b0, bits, inh_len, start_ok);
    rst_n = 1'b0;
    #1;
    check_eq("abort_lines", {30'd0, ps2clk_oe, ps2data_oe}, 32'd0);
    check_eq("abort_busy", {31'd0, busy}, 32'd0);
    cycles(2);
    dev_clk = 1'b1;
    rst_n   = 1'b1;
    cycles(50);
    check_eq("abort_no_done", done_cnt - done0, 32'd0);
    read_reg(PS2TXREG, st, oe);
    check_eq("abort_status", {24'd0, st}, 32'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
